// File: rtl/alu_issue_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_queue_if
//  Description : Handshake/data bundle between decode, the ALU issue queue and
//                the ALU. The queue side uses modport "slave". The environment
//                side (decode source plus ALU consumer) uses modport "master".
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Signals
//    in_valid   decode -> queue   triple presented this cycle
//    in_ready   queue  -> decode  queue can accept (push = in_valid & in_ready)
//    in_op1     decode -> queue   operand 1
//    in_op2     decode -> queue   operand 2
//    in_oprn    decode -> queue   ALU operation code
//    alu_valid  queue  -> ALU     head entry valid
//    alu_accept ALU    -> queue   consumer takes head (pop = alu_valid & alu_accept)
//    alu_op1    queue  -> ALU     head operand 1 (0 when empty)
//    alu_op2    queue  -> ALU     head operand 2 (0 when empty)
//    alu_oprn   queue  -> ALU     head opcode    (0 when empty)
//    illegal    queue  -> monitor one-cycle pulse, illegal opcode dropped
//    count      queue  -> monitor entries held, 0..DEPTH
// ============================================================================
interface alu_issue_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OPRN_WIDTH = 6,
    parameter int CNT_WIDTH  = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_op1;
    logic [DATA_WIDTH-1:0] in_op2;
    logic [OPRN_WIDTH-1:0] in_oprn;
    logic                  alu_valid;
    logic                  alu_accept;
    logic [DATA_WIDTH-1:0] alu_op1;
    logic [DATA_WIDTH-1:0] alu_op2;
    logic [OPRN_WIDTH-1:0] alu_oprn;
    logic                  illegal;
    logic [CNT_WIDTH-1:0]  count;

    modport slave (
        input  in_valid, in_op1, in_op2, in_oprn, alu_accept,
        output in_ready, alu_valid, alu_op1, alu_op2, alu_oprn, illegal, count
    );

    modport master (
        output in_valid, in_op1, in_op2, in_oprn, alu_accept,
        input  in_ready, alu_valid, alu_op1, alu_op2, alu_oprn, illegal, count
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_queue
//  Description : Small FIFO issue queue in front of the 32-bit combinational
//                ALU. Buffers {op1, op2, oprn} triples from decode and presents
//                the oldest one with a valid/accept handshake. Illegal opcodes
//                are consumed at the input, never stored, and flagged with a
//                one-cycle pulse on illegal.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk   in   rising-edge clock
//    rst   in   asynchronous reset, active-high
//    bus   slave modport of alu_issue_queue_if (decode input, ALU output,
//          illegal pulse, occupancy count)
// ============================================================================
module alu_issue_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int OPRN_WIDTH = 6,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  wire logic          clk,
    input  wire logic          rst,
    alu_issue_queue_if.slave   bus
);

    localparam int                    PTR_WIDTH = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0]  C_DEPTH   = CNT_WIDTH'(DEPTH);
    localparam logic [OPRN_WIDTH-1:0] C_OP_MIN  = OPRN_WIDTH'(1);
    localparam logic [OPRN_WIDTH-1:0] C_OP_MAX  = OPRN_WIDTH'(9);

    // Entry storage carries no reset: contents are only ever observed through
    // the head mux, which is gated by a non-zero count.
    logic [DATA_WIDTH-1:0] r_op1_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] r_op2_mem  [DEPTH];
    logic [OPRN_WIDTH-1:0] r_oprn_mem [DEPTH];

    logic [PTR_WIDTH-1:0]  r_wr_ptr;
    logic [PTR_WIDTH-1:0]  r_rd_ptr;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_illegal;

    logic                  w_in_ready;
    logic                  w_alu_valid;
    logic                  w_oprn_legal;
    logic                  w_push;
    logic                  w_push_legal;
    logic                  w_push_illegal;
    logic                  w_pop;

    // Ready depends on registered occupancy only, so a pop on a full queue
    // does not open the input until the following cycle.
    assign w_in_ready  = (r_count < C_DEPTH);
    assign w_alu_valid = (r_count != '0);

    // Legal range 0x01..0x09. A full-width compare also rejects any set bit
    // above the low nibble.
    assign w_oprn_legal = (bus.in_oprn >= C_OP_MIN) && (bus.in_oprn <= C_OP_MAX);

    assign w_push         = bus.in_valid & w_in_ready;
    assign w_push_legal   = w_push & w_oprn_legal;
    assign w_push_illegal = w_push & ~w_oprn_legal;
    assign w_pop          = w_alu_valid & bus.alu_accept;

    // Storage write.
    always_ff @(posedge clk) begin
        if (w_push_legal) begin
            r_op1_mem[r_wr_ptr]  <= bus.in_op1;
            r_op2_mem[r_wr_ptr]  <= bus.in_op2;
            r_oprn_mem[r_wr_ptr] <= bus.in_oprn;
        end
    end

    // Pointers, occupancy and the illegal-drop pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_push_illegal;

            // DEPTH is a power of two, so natural pointer overflow is the wrap.
            if (w_push_legal) begin
                r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
            end

            case ({w_push_legal, w_pop})
                2'b10:   r_count <= r_count + CNT_WIDTH'(1);
                2'b01:   r_count <= r_count - CNT_WIDTH'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head presentation: forced to zero when empty so the ALU sees a no-op.
    always_comb begin
        bus.alu_op1  = '0;
        bus.alu_op2  = '0;
        bus.alu_oprn = '0;
        if (w_alu_valid) begin
            bus.alu_op1  = r_op1_mem[r_rd_ptr];
            bus.alu_op2  = r_op2_mem[r_rd_ptr];
            bus.alu_oprn = r_oprn_mem[r_rd_ptr];
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.alu_valid = w_alu_valid;
    assign bus.illegal   = r_illegal;
    assign bus.count     = r_count;

endmodule
`default_nettype wire
